// File: rtl/bcrypt_arbiter_multi_if.sv
// Bundle between the bcrypt arbiter, its cores and the shared BRAM port A.
// The slave modport is the arbiter's view, the master modport the environment's.
interface bcrypt_arbiter_multi_if #(
    parameter int NUM_CORES = 14,
    parameter int DW        = 32,
    parameter int AW        = 32,
    parameter int IDX_W     = 6
);
    logic                        go;
    logic [NUM_CORES-1:0]        core_mask;
    logic [2*NUM_CORES-1:0]      core_cmd;
    logic [2*NUM_CORES-1:0]      core_done;
    logic [NUM_CORES*DW/8-1:0]   core_we;
    logic [NUM_CORES*AW-1:0]     core_addr;
    logic [NUM_CORES*DW-1:0]     core_wdata;
    logic                        BRAM_Rst_A;
    logic                        BRAM_Clk_A;
    logic                        BRAM_En_A;
    logic [DW/8-1:0]             BRAM_WE_A;
    logic [AW-1:0]               BRAM_Addr_A;
    logic [DW-1:0]               BRAM_WrData_A;
    logic                        busy;
    logic [DW-1:0]               all_done;
    logic                        error;
    logic [IDX_W-1:0]            err_core;
    logic [IDX_W-1:0]            cur_core;

    modport slave (
        input  go, core_mask, core_done, core_we, core_addr, core_wdata,
        output core_cmd, BRAM_Rst_A, BRAM_Clk_A, BRAM_En_A, BRAM_WE_A,
        output BRAM_Addr_A, BRAM_WrData_A, busy, all_done, error,
        output err_core, cur_core
    );

    modport master (
        output go, core_mask, core_done, core_we, core_addr, core_wdata,
        input  core_cmd, BRAM_Rst_A, BRAM_Clk_A, BRAM_En_A, BRAM_WE_A,
        input  BRAM_Addr_A, BRAM_WrData_A, busy, all_done, error,
        input  err_core, cur_core
    );
endinterface

// File: rtl/bcrypt_arbiter_multi.sv
// Sequences N bcrypt cores through LOAD / COMPUTE / STORE and grants the
// single shared BRAM port A to one core at a time, with a per-wait watchdog.
module bcrypt_arbiter_multi #(
    parameter int          NUM_CORES = 14,
    parameter int          DW        = 32,
    parameter int          AW        = 32,
    parameter int          IDX_W     = 6,
    parameter logic [31:0] TIMEOUT   = 32'd100000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bcrypt_arbiter_multi_if.slave  bus
);
    localparam int BW = DW / 8;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WLOAD, S_COMP, S_WCOMP,
        S_STORE, S_WSTORE, S_DONE, S_ERR
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       cur_q, cur_d;
    logic [NUM_CORES-1:0]   mask_q, mask_d;
    logic [2*NUM_CORES-1:0] cmd_q, cmd_d;
    logic [31:0]            wd_q, wd_d;
    logic                   err_q, err_d;
    logic [IDX_W-1:0]       errc_q, errc_d;
    logic [DW-1:0]          alld_q, alld_d;
    logic                   busy_q, busy_d;
    logic [BW-1:0]          we_q, we_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [DW-1:0]          wdata_q, wdata_d;

    logic [1:0]             done_sel, cmd_sel;
    logic                   mask_sel;
    logic [BW-1:0]          we_sel;
    logic [AW-1:0]          addr_sel;
    logic [DW-1:0]          wdata_sel;
    logic                   at_end, grant, rem_empty, hit;
    logic [31:0]            wd_inc;
    logic                   cmd_clr, cmd_wen;
    logic [1:0]             cmd_wv;
    logic [IDX_W-1:0]       cur_inc;

    // Index mux; an out-of-range index (== NUM_CORES) selects nothing.
    always_comb begin
        done_sel  = '0;
        cmd_sel   = '0;
        mask_sel  = 1'b0;
        we_sel    = '0;
        addr_sel  = '0;
        wdata_sel = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (cur_q == IDX_W'(i)) begin
                done_sel  = bus.core_done[2*i +: 2];
                cmd_sel   = cmd_q[2*i +: 2];
                mask_sel  = mask_q[i];
                we_sel    = bus.core_we[i*BW +: BW];
                addr_sel  = bus.core_addr[i*AW +: AW];
                wdata_sel = bus.core_wdata[i*DW +: DW];
            end
        end
    end

    assign at_end    = (cur_q == IDX_W'(NUM_CORES));
    assign cur_inc   = cur_q + 1'b1;
    assign rem_empty = ((mask_q >> cur_q) == '0);
    assign wd_inc    = wd_q + 32'd1;
    assign hit       = (TIMEOUT != 32'd0) && (wd_inc == TIMEOUT);
    assign grant     = (state_q inside {S_LOAD, S_WLOAD, S_STORE, S_WSTORE})
                    && (cmd_sel == 2'b01 || cmd_sel == 2'b11);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        mask_d  = mask_q;
        cmd_d   = cmd_q;
        wd_d    = wd_q;
        err_d   = err_q;
        errc_d  = errc_q;
        we_d    = '0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cmd_clr = 1'b0;
        cmd_wen = 1'b0;
        cmd_wv  = 2'b00;
        if (grant) begin
            we_d    = we_sel;
            addr_d  = addr_sel;
            wdata_d = wdata_sel;
        end
        if (!bus.go) begin
            state_d = S_IDLE;
            cur_d   = '0;
            wd_d    = '0;
            err_d   = 1'b0;
            we_d    = '0;
            cmd_clr = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    mask_d  = bus.core_mask;
                    cur_d   = '0;
                    state_d = S_LOAD;
                end
                S_LOAD, S_STORE: begin
                    if (at_end) begin
                        cur_d   = '0;
                        state_d = (state_q == S_LOAD) ? S_COMP : S_DONE;
                    end else if (mask_sel) begin
                        cmd_wen = 1'b1;
                        cmd_wv  = (state_q == S_LOAD) ? 2'b01 : 2'b11;
                        wd_d    = '0;
                        state_d = (state_q == S_LOAD) ? S_WLOAD : S_WSTORE;
                    end else begin
                        cur_d = cur_inc;
                    end
                end
                S_COMP: begin
                    cmd_wen = mask_sel;
                    cmd_wv  = 2'b10;
                    if (cur_q >= IDX_W'(NUM_CORES - 1)) begin
                        cur_d   = '0;
                        wd_d    = '0;
                        state_d = S_WCOMP;
                    end else begin
                        cur_d = cur_inc;
                    end
                end
                S_WLOAD, S_WCOMP, S_WSTORE: begin
                    // A done in the terminal-count cycle still wins.
                    if (state_q == S_WCOMP && rem_empty) begin
                        cur_d   = '0;
                        state_d = S_STORE;
                    end else if ((state_q == S_WCOMP && !mask_sel)
                              || (state_q == S_WLOAD && done_sel == 2'b01)
                              || (state_q == S_WCOMP && done_sel == 2'b10)
                              || (state_q == S_WSTORE && done_sel == 2'b11)) begin
                        cur_d   = cur_inc;
                        wd_d    = '0;
                        cmd_wen = (state_q == S_WSTORE);
                        cmd_wv  = 2'b00;
                        if (state_q == S_WLOAD)  state_d = S_LOAD;
                        if (state_q == S_WSTORE) state_d = S_STORE;
                    end else if (hit) begin
                        err_d   = 1'b1;
                        errc_d  = cur_q;
                        cmd_clr = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        wd_d = wd_inc;
                    end
                end
                S_DONE, S_ERR: state_d = state_q;
                default:       state_d = S_IDLE;
            endcase
        end
        if (cmd_clr) begin
            cmd_d = '0;
        end else if (cmd_wen) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (cur_q == IDX_W'(i)) cmd_d[2*i +: 2] = cmd_wv;
            end
        end
        alld_d = (state_d == S_DONE) ? DW'(8'hFF) : '0;
        busy_d = !(state_d inside {S_IDLE, S_DONE, S_ERR});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            mask_q  <= '0;
            cmd_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            errc_q  <= '0;
            alld_q  <= '0;
            busy_q  <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            mask_q  <= mask_d;
            cmd_q   <= cmd_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            errc_q  <= errc_d;
            alld_q  <= alld_d;
            busy_q  <= busy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign bus.core_cmd      = cmd_q;
    assign bus.BRAM_Rst_A    = 1'b0;
    assign bus.BRAM_Clk_A    = clk;
    assign bus.BRAM_En_A     = 1'b1;
    assign bus.BRAM_WE_A     = we_q;
    assign bus.BRAM_Addr_A   = addr_q;
    assign bus.BRAM_WrData_A = wdata_q;
    assign bus.busy          = busy_q;
    assign bus.all_done      = alld_q;
    assign bus.error         = err_q;
    assign bus.err_core      = errc_q;
    assign bus.cur_core      = cur_q;
endmodule

// File: tb/tb_bcrypt_arbiter_multi.sv
// Directed bench for bcrypt_arbiter_multi with four modelled cores that
// answer each command two cycles after it appears.
module tb_bcrypt_arbiter_multi;
    localparam int NC = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bcrypt_arbiter_multi_if #(.NUM_CORES(NC), .DW(32), .AW(32), .IDX_W(3)) bus ();

    bcrypt_arbiter_multi #(
        .NUM_CORES(NC), .DW(32), .AW(32), .IDX_W(3), .TIMEOUT(32'd50)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int total = 0;
    int bad = 0;
    logic [31:0] cyc = '0;
    logic kill2;
    logic mon_clr;
    logic [1:0] prev_c [NC] = '{default: 2'b00};
    logic [1:0] age [NC] = '{default: 2'b00};
    logic [1:0] last_c [NC] = '{default: 2'b00};
    logic [7:0] hist [NC] = '{default: 8'h00};
    logic seen_we = 1'b0;
    logic seen_wef = 1'b0;
    logic seen13 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.core_we = 16'hF4F1;
    for (genvar g = 0; g < NC; g++) begin : g_core
        assign bus.core_addr[g*32 +: 32]  = {8'(g), 8'hA5, cyc[15:0]};
        assign bus.core_wdata[g*32 +: 32] = {cyc[15:0], 8'(g), 8'h5A};
    end

    always @(posedge clk) begin
        for (int i = 0; i < NC; i++) begin
            prev_c[i] <= bus.core_cmd[2*i +: 2];
            if (bus.core_cmd[2*i +: 2] != prev_c[i]) age[i] <= 2'd0;
            else if (age[i] != 2'd3) age[i] <= age[i] + 2'd1;
        end
    end

    always_comb begin
        bus.core_done = '0;
        for (int i = 0; i < NC; i++) begin
            if (bus.core_cmd[2*i +: 2] != 2'b00
                && bus.core_cmd[2*i +: 2] == prev_c[i] && age[i] >= 2'd1
                && !(kill2 && i == 2 && bus.core_cmd[2*i +: 2] == 2'b10))
                bus.core_done[2*i +: 2] = bus.core_cmd[2*i +: 2];
        end
    end

    always @(posedge clk) begin
        if (mon_clr) begin
            seen_we  <= 1'b0;
            seen_wef <= 1'b0;
            seen13   <= 1'b0;
            for (int i = 0; i < NC; i++) begin
                hist[i]   <= 8'h00;
                last_c[i] <= bus.core_cmd[2*i +: 2];
            end
        end else begin
            if (bus.BRAM_WE_A != 4'h0) seen_we <= 1'b1;
            if (bus.BRAM_WE_A == 4'hF) seen_wef <= 1'b1;
            if (bus.core_cmd[3:2] != 2'b00 || bus.core_cmd[7:6] != 2'b00)
                seen13 <= 1'b1;
            for (int i = 0; i < NC; i++) begin
                if (bus.core_cmd[2*i +: 2] != last_c[i]) begin
                    hist[i]   <= {hist[i][5:0], bus.core_cmd[2*i +: 2]};
                    last_c[i] <= bus.core_cmd[2*i +: 2];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (bus.all_done != 32'hFF && n < max) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic start(input logic [3:0] m);
        bus.core_mask = m;
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        bus.go = 1'b1;
    endtask

    task automatic stop();
        bus.go = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_vals(input string p);
        check({p, "_cmd"}, 64'(bus.core_cmd), 64'h0);
        check({p, "_cur"}, 64'(bus.cur_core), 64'h0);
        check({p, "_we"}, 64'(bus.BRAM_WE_A), 64'h0);
        check({p, "_addr"}, 64'(bus.BRAM_Addr_A), 64'h0);
        check({p, "_wdata"}, 64'(bus.BRAM_WrData_A), 64'h0);
        check({p, "_alldone"}, 64'(bus.all_done), 64'h0);
        check({p, "_error"}, 64'(bus.error), 64'h0);
        check({p, "_errcore"}, 64'(bus.err_core), 64'h0);
        check({p, "_busy"}, 64'(bus.busy), 64'h0);
    endtask

    initial begin
        int n;
        logic [31:0] ea, ed;
        bus.go = 1'b0;
        bus.core_mask = '0;
        kill2 = 1'b0;
        mon_clr = 1'b0;
        rst_n = 1'b0;
        #2;
        reset_vals("rst");
        #10 rst_n = 1'b1;
        @(negedge clk);

        start(4'hF);
        n = 0;
        while (bus.core_cmd[1:0] != 2'b01 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("load0_reached", 64'(n < 100), 64'h1);
        check("we_before_grant", 64'(bus.BRAM_WE_A), 64'h0);
        ea = {8'd0, 8'hA5, cyc[15:0]};
        ed = {cyc[15:0], 8'd0, 8'h5A};
        @(negedge clk);
        check("bram_addr_lag", 64'(bus.BRAM_Addr_A), 64'(ea));
        check("bram_we_core0", 64'(bus.BRAM_WE_A), 64'h1);
        check("bram_wdata_lag", 64'(bus.BRAM_WrData_A), 64'(ed));
        wait_done(400, n);
        check("full_alldone", 64'(bus.all_done), 64'hFF);
        check("full_busy", 64'(bus.busy), 64'h0);
        for (int i = 0; i < NC; i++)
            check($sformatf("full_hist%0d", i), 64'(hist[i]), 64'h6C);
        stop();
        check("go0_alldone", 64'(bus.all_done), 64'h0);

        start(4'b0101);
        wait_done(400, n);
        check("m5_alldone", 64'(bus.all_done), 64'hFF);
        check("m5_no_cmd13", 64'(seen13), 64'h0);
        check("m5_no_we13", 64'(seen_wef), 64'h0);
        stop();

        start(4'h0);
        wait_done(60, n);
        check("m0_cycles", 64'(n), 64'(3 * (NC + 1) + 1));
        check("m0_alldone", 64'(bus.all_done), 64'hFF);
        check("m0_no_we", 64'(seen_we), 64'h0);
        stop();

        kill2 = 1'b1;
        start(4'hF);
        n = 0;
        while (!(bus.cur_core == 3'd2 && bus.core_cmd == 8'hAA) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("wc2_reached", 64'(n < 300), 64'h1);
        repeat (49) @(negedge clk);
        check("to_early", 64'(bus.error), 64'h0);
        @(negedge clk);
        check("to_error", 64'(bus.error), 64'h1);
        check("to_errcore", 64'(bus.err_core), 64'h2);
        check("to_cmd", 64'(bus.core_cmd), 64'h0);
        check("to_busy", 64'(bus.busy), 64'h0);
        repeat (3) @(negedge clk);
        check("to_hold", 64'(bus.error), 64'h1);
        stop();
        check("to_clear", 64'(bus.error), 64'h0);
        kill2 = 1'b0;

        start(4'hF);
        n = 0;
        while (bus.core_cmd[3:2] != 2'b11 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("ws1_reached", 64'(n < 400), 64'h1);
        bus.go = 1'b0;
        @(negedge clk);
        check("drop_cmd", 64'(bus.core_cmd), 64'h0);
        check("drop_we", 64'(bus.BRAM_WE_A), 64'h0);
        check("drop_alldone", 64'(bus.all_done), 64'h0);
        check("drop_busy", 64'(bus.busy), 64'h0);
        check("drop_cur", 64'(bus.cur_core), 64'h0);

        start(4'hF);
        n = 0;
        while (bus.core_cmd[3:2] != 2'b01 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wl1_reached", 64'(n < 100), 64'h1);
        check("wl1_busy", 64'(bus.busy), 64'h1);
        #3 rst_n = 1'b0;
        #1;
        reset_vals("arst");
        bus.go = 1'b0;
        #8 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", 64'(bus.busy), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
